// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU memory subsystem: requester port indices,
// arbiter state encoding and default bus widths.
package cpu_pkg;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 12;

    localparam int P_IF  = 0;
    localparam int P_LS  = 1;
    localparam int P_DBG = 2;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        YIELD = 2'd2
    } arb_state_e;

    // One-hot {DBG,LS,IF} to port index; an empty vector maps to IF.
    function automatic logic [1:0] oh2idx(input logic [2:0] oh);
        case (oh)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: the search starts at the port after ptr_i
// (IF, LS, DBG, wrap) and the first requesting port wins.
module rr_pick3
    import cpu_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] win_o
);

    // Priority order rotates with the last winner.
    always_comb begin
        win_o = 3'b000;
        case (ptr_i)
            2'd0: begin
                if (req_i[P_LS])       win_o = 3'b010;
                else if (req_i[P_DBG]) win_o = 3'b100;
                else if (req_i[P_IF])  win_o = 3'b001;
                else                   win_o = 3'b000;
            end
            2'd1: begin
                if (req_i[P_DBG])      win_o = 3'b100;
                else if (req_i[P_IF])  win_o = 3'b001;
                else if (req_i[P_LS])  win_o = 3'b010;
                else                   win_o = 3'b000;
            end
            default: begin
                if (req_i[P_IF])       win_o = 3'b001;
                else if (req_i[P_LS])  win_o = 3'b010;
                else if (req_i[P_DBG]) win_o = 3'b100;
                else                   win_o = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port CPU memory between instruction fetch,
// load/store and the debug loader, with bounded DBG burst locking.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);
    localparam logic [LW-1:0] CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};

    arb_state_e        state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        rvalid_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic [2:0]        req_s;
    logic [2:0]        elig_s;
    logic [2:0]        win_s;
    logic [LW-1:0]     cnt_inc_s;

    assign req_s     = {dbg_req, ls_req, if_req};
    assign cnt_inc_s = lock_cnt_q + CNT_ONE;

    // The port granted this cycle is masked so a held request is not granted twice.
    always_comb begin
        elig_s = 3'b000;
        case (state_q)
            ARB:     elig_s = req_s & ~gnt_q;
            YIELD:   elig_s = req_s & ~gnt_q & 3'b011;
            default: elig_s = 3'b000;
        endcase
    end

    rr_pick3 u_pick (
        .req_i (elig_s),
        .ptr_i (rr_ptr_q),
        .win_o (win_s)
    );

    // Next-state decision and registered memory mux.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = lock_cnt_q;
        gnt_d       = 3'b000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;

        if (en) begin
            case (state_q)
                ARB: begin
                    if (win_s != 3'b000) begin
                        gnt_d    = win_s;
                        rr_ptr_d = oh2idx(win_s);
                        if (win_s[P_DBG] && dbg_lock) begin
                            state_d    = LOCK;
                            lock_cnt_d = CNT_ONE;
                        end else begin
                            state_d = ARB;
                        end
                    end else begin
                        gnt_d = 3'b000;
                    end
                end
                LOCK: begin
                    if (dbg_req && dbg_lock) begin
                        gnt_d      = 3'b100;
                        lock_cnt_d = cnt_inc_s;
                        // Saturate into YIELD so IF/LS get one decision.
                        if (cnt_inc_s == LOCK_MAX) begin
                            state_d = YIELD;
                        end else begin
                            state_d = LOCK;
                        end
                    end else begin
                        state_d    = ARB;
                        lock_cnt_d = {LW{1'b0}};
                    end
                end
                YIELD: begin
                    gnt_d      = win_s;
                    state_d    = ARB;
                    lock_cnt_d = {LW{1'b0}};
                    if (win_s != 3'b000) begin
                        rr_ptr_d = oh2idx(win_s);
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end
                default: begin
                    state_d    = ARB;
                    lock_cnt_d = {LW{1'b0}};
                end
            endcase
        end else begin
            gnt_d = 3'b000;
        end

        case (gnt_d)
            3'b001: begin
                mem_addr_d = if_addr;
                mem_we_d   = 1'b0;
            end
            3'b010: begin
                mem_addr_d  = ls_addr;
                mem_wdata_d = ls_wdata;
                mem_we_d    = ls_we;
            end
            3'b100: begin
                mem_addr_d  = dbg_addr;
                mem_wdata_d = dbg_wdata;
                mem_we_d    = dbg_we;
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State, pointer, grant and memory drive registers; rvalid follows a read grant by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rr_ptr_q    <= 2'd2;
            lock_cnt_q  <= {LW{1'b0}};
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= gnt_q & {3{~mem_we_q}};
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = mem_rdata;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous memory model; MAX_LOCK=4 so the
// lock/yield sequence stays short.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        if_req, ls_req, ls_we, dbg_req, dbg_lock, dbg_we;
    logic [11:0] if_addr, ls_addr, dbg_addr;
    logic [18:0] ls_wdata, dbg_wdata;
    logic [2:0]  gnt, rvalid;
    logic [18:0] rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;

    logic [18:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    logic [2:0] seq_rr   [0:5];
    logic [2:0] seq_lock [0:5];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(19), .ADDR_W(12), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .dbg_req   (dbg_req),
        .dbg_lock  (dbg_lock),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Single-port synchronous memory: read-before-write, data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_req(input logic v);
        if_req  = v;
        ls_req  = v;
        dbg_req = v;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'h0;
        mem[16] = 19'h4ABCD;
        mem_rdata = 19'h0;
        seq_rr[0] = 3'b001; seq_rr[1] = 3'b010; seq_rr[2] = 3'b100;
        seq_rr[3] = 3'b001; seq_rr[4] = 3'b010; seq_rr[5] = 3'b100;
        seq_lock[0] = 3'b100; seq_lock[1] = 3'b100; seq_lock[2] = 3'b100;
        seq_lock[3] = 3'b100; seq_lock[4] = 3'b001; seq_lock[5] = 3'b100;

        rst = 1'b1; en = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0;
        if_addr = 12'h0; ls_addr = 12'h0; dbg_addr = 12'h0; ls_wdata = 19'h0; dbg_wdata = 19'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {13'd0, mem_wdata}, 32'd0);
        rst = 1'b0;

        // Single IF read, request held through the grant cycle.
        if_addr = 12'h010; if_req = 1'b1;
        tick();
        chk("rd_gnt", {29'd0, gnt}, 32'h1);
        chk("rd_addr", {20'd0, mem_addr}, 32'h010);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("rd_nodouble", {29'd0, gnt}, 32'd0);
        chk("rd_rvalid", {29'd0, rvalid}, 32'h1);
        chk("rd_rdata", {13'd0, rdata}, 32'h4ABCD);
        if_req = 1'b0;
        tick();
        chk("rd_rvalid_off", {29'd0, rvalid}, 32'd0);

        // Asynchronous reset in the middle of a read.
        if_req = 1'b1;
        tick();
        chk("mr_gnt", {29'd0, gnt}, 32'h1);
        if_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mr_gnt_clr", {29'd0, gnt}, 32'd0);
        chk("mr_we_clr", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("mr_rvalid_drop", {29'd0, rvalid}, 32'd0);
        rst = 1'b0;

        // Contention: all three held high right after reset.
        if_addr = 12'h010; ls_addr = 12'h011; dbg_addr = 12'h012;
        all_req(1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), {29'd0, gnt}, {29'd0, seq_rr[i]});
            if (i > 0) chk($sformatf("rr_rvalid%0d", i), {29'd0, rvalid}, {29'd0, seq_rr[i-1]});
        end
        all_req(1'b0);
        tick();
        tick();

        // LS write, then read back through IF.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 12'h020; ls_wdata = 19'h12345;
        tick();
        chk("wr_gnt", {29'd0, gnt}, 32'h2);
        chk("wr_we", {31'd0, mem_we}, 32'h1);
        chk("wr_addr", {20'd0, mem_addr}, 32'h020);
        chk("wr_wdata", {13'd0, mem_wdata}, 32'h12345);
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        chk("wr_no_rvalid", {29'd0, rvalid}, 32'd0);
        chk("wr_we_off", {31'd0, mem_we}, 32'd0);
        if_addr = 12'h020; if_req = 1'b1;
        tick();
        chk("rb_gnt", {29'd0, gnt}, 32'h1);
        if_req = 1'b0;
        tick();
        chk("rb_rvalid", {29'd0, rvalid}, 32'h1);
        chk("rb_rdata", {13'd0, rdata}, 32'h12345);
        tick();

        // DBG burst lock with IF waiting: four DBG, forced yield to IF, DBG again.
        if_addr = 12'h010; if_req = 1'b1;
        dbg_addr = 12'h030; dbg_req = 1'b1; dbg_lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("lk_gnt%0d", i), {29'd0, gnt}, {29'd0, seq_lock[i]});
        end
        all_req(1'b0); dbg_lock = 1'b0;
        tick();
        chk("lk_release", {29'd0, gnt}, 32'd0);
        tick();

        // Enable gating: grant IF, then hold en low with every request high.
        all_req(1'b1);
        tick();
        chk("en_gnt0", {29'd0, gnt}, 32'h1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("en_off_gnt%0d", i), {29'd0, gnt}, 32'd0);
            chk($sformatf("en_off_we%0d", i), {31'd0, mem_we}, 32'd0);
            if (i == 0) chk("en_rvalid_due", {29'd0, rvalid}, 32'h1);
            else chk($sformatf("en_rvalid_off%0d", i), {29'd0, rvalid}, 32'd0);
        end
        en = 1'b1;
        tick();
        chk("en_resume", {29'd0, gnt}, 32'h2);
        all_req(1'b0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
